// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer for im_4k: owns the fetch PC, buffers fetched words with
// their PCs in a 2-entry prefetch FIFO and presents them to decode over valid/ready.
module im_fetch_ctrl #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_dout,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg;
    logic [1:0]  count_reg;
    logic        rd_ptr_reg, wr_ptr_reg;
    logic        push, pop;

    logic [31:0] pc_mem   [2];
    logic [31:0] word_mem [2];

    assign im_addr    = fetch_pc_reg[ADDR_W+1:2];
    assign inst_valid = (count_reg != 2'd0);
    assign inst       = inst_valid ? word_mem[rd_ptr_reg] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg]   : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A push at a full buffer is only allowed when the head leaves in the same cycle.
    always_comb begin
        state_next = fetch_en ? FETCH : IDLE;
        pop        = inst_valid & inst_ready;
        push       = (state_reg == FETCH) & fetch_en & ~redirect &
                     ((count_reg < 2'd2) | pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else if (redirect) begin
            fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            if (push) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
                wr_ptr_reg   <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count_reg says they are live.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    pc_mem[gi]   <= fetch_pc_reg;
                    word_mem[gi] <= im_dout;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: a queue of expected (pc, word) pairs is compared
// against every completed decode transfer, plus timing/backpressure/reset spot checks.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect, inst_ready, inst_valid;
    logic [31:0] redirect_pc, im_dout, inst, inst_pc;
    logic [9:0]  im_addr;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    logic [31:0] gen_pc, last_pc, tmp_pc;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // im_4k model: word i holds 0x1000_0000 + i
    assign im_dout = 32'h1000_0000 + {22'd0, im_addr};

    im_fetch_ctrl #(.ADDR_W(10), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .im_addr(im_addr),
        .im_dout(im_dout), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + {22'd0, pc[11:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        q.delete();
        gen_pc = pc;
    endtask

    // One cycle: optionally check inst_valid, score any transfer, advance to next negedge.
    task automatic tick(input int expv);
        exp_t e;
        #1;
        while (q.size() < 4) begin
            q.push_back('{pc: gen_pc, word: word_of(gen_pc)});
            gen_pc += 32'd4;
        end
        if (expv >= 0) chk("inst_valid", {31'd0, inst_valid}, expv[31:0]);
        if (inst_valid && inst_ready) begin
            e = q.pop_front();
            $display("pop pc=%h inst=%h im_addr=%h", inst_pc, inst, im_addr);
            chk("inst_pc", inst_pc, e.pc);
            chk("inst", inst, e.word);
            last_pc = e.pc;
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cycles);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (inst_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_valid", {31'd0, found}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        inst_ready = 1'b1; last_pc = 32'h0;
        restart(32'h3000);
        #2;
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_im_addr", {22'd0, im_addr}, 32'h0);

        // 1: streaming from RESET_PC at one entry per cycle
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; fetch_en = 1'b1;
        tick(0);
        wait_valid(4);
        repeat (8) tick(1);

        // 2: backpressure saturates buffer and freezes im_addr at head+2
        inst_ready = 1'b0;
        repeat (5) tick(1);
        tmp_pc = last_pc + 32'd12;
        chk("bp_im_addr", {22'd0, im_addr}, {22'd0, tmp_pc[11:2]});
        inst_ready = 1'b1;
        repeat (6) tick(1);

        // 3: redirect to unaligned PC
        redirect = 1'b1; redirect_pc = 32'h3023;
        tick(1);
        redirect = 1'b0;
        restart(32'h3020);
        tick(0);
        repeat (3) tick(1);

        // 4: redirect near the top of im_4k; address wraps to word 0
        redirect = 1'b1; redirect_pc = 32'h3FFC;
        tick(-1);
        redirect = 1'b0;
        restart(32'h3FFC);
        chk("wrap_addr_hi", {22'd0, im_addr}, 32'h3FF);
        tick(0);
        chk("wrap_addr_lo", {22'd0, im_addr}, 32'h000);
        repeat (3) tick(1);

        // 6: fetch_en low with full buffer drains two entries, then holds PC
        inst_ready = 1'b0;
        repeat (3) tick(-1);
        fetch_en = 1'b0; inst_ready = 1'b1;
        tick(1);
        tick(1);
        tick(0);
        tick(0);
        tmp_pc = last_pc + 32'd4;
        chk("hold_im_addr", {22'd0, im_addr}, {22'd0, tmp_pc[11:2]});
        fetch_en = 1'b1;
        wait_valid(4);
        repeat (3) tick(1);

        // 5: asynchronous reset with a full buffer
        inst_ready = 1'b0;
        repeat (3) tick(-1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_im_addr", {22'd0, im_addr}, 32'h0);
        @(negedge clk);
        restart(32'h3000);
        rst_n = 1'b1; inst_ready = 1'b1;
        tick(0);
        wait_valid(4);
        repeat (4) tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
